// File: rtl/m2vside_pkg.sv
// Shared constants for the MPEG2 side-information queue: default field widths,
// record width helper and the bit offsets of the fixed-width low fields.
package m2vside_pkg;

  localparam int DEF_MVH_WIDTH = 16;
  localparam int DEF_MVV_WIDTH = 15;
  localparam int DEF_MBX_WIDTH = 6;
  localparam int DEF_MBY_WIDTH = 5;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_PTR_WIDTH = 2;

  // Record layout, MSB first: {mv_h, mv_v, mb_x, mb_y, mb_intra, block, coded, enable}
  localparam int OFF_ENABLE = 0;
  localparam int OFF_CODED  = 1;
  localparam int OFF_BLOCK  = 2;
  localparam int OFF_INTRA  = 5;
  localparam int OFF_MBY    = 6;

  localparam int DEF_OFF_MBX = OFF_MBY + DEF_MBY_WIDTH;
  localparam int DEF_OFF_MVV = DEF_OFF_MBX + DEF_MBX_WIDTH;
  localparam int DEF_OFF_MVH = DEF_OFF_MVV + DEF_MVV_WIDTH;

  function automatic int rec_width(input int mvh, input int mvv, input int mbx, input int mby);
    return mvh + mvv + mbx + mby + 6;
  endfunction

  localparam int DEF_REC_WIDTH = rec_width(DEF_MVH_WIDTH, DEF_MVV_WIDTH,
                                           DEF_MBX_WIDTH, DEF_MBY_WIDTH);

endpackage

// File: rtl/m2vside_ram.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module m2vside_ram #(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2,
  parameter int WIDTH     = 48
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PTR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [PTR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/m2vside_fifo.sv
// Side-information queue between VLD front end and IDCT/MC back end.
// Define M2VSIDE_FIFO_ERR_EN to build the sticky ovf/udf flag registers.
module m2vside_fifo
  import m2vside_pkg::*;
#(
  parameter int MVH_WIDTH = DEF_MVH_WIDTH,
  parameter int MVV_WIDTH = DEF_MVV_WIDTH,
  parameter int MBX_WIDTH = DEF_MBX_WIDTH,
  parameter int MBY_WIDTH = DEF_MBY_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR_WIDTH = DEF_PTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MVH_WIDTH-1:0] in_mv_h,
  input  logic [MVV_WIDTH-1:0] in_mv_v,
  input  logic [MBX_WIDTH-1:0] in_mb_x,
  input  logic [MBY_WIDTH-1:0] in_mb_y,
  input  logic                 in_mb_intra,
  input  logic [2:0]           in_block,
  input  logic                 in_coded,
  input  logic                 in_enable,
  input  logic                 push,
  input  logic                 pop,
  output logic [MVH_WIDTH-1:0] out_mv_h,
  output logic [MVV_WIDTH-1:0] out_mv_v,
  output logic [MBX_WIDTH-1:0] out_mb_x,
  output logic [MBY_WIDTH-1:0] out_mb_y,
  output logic                 out_mb_intra,
  output logic [2:0]           out_block,
  output logic                 out_coded,
  output logic                 out_enable,
  output logic                 empty,
  output logic                 full,
  output logic [PTR_WIDTH:0]   level,
  output logic                 ovf,
  output logic                 udf
);

  localparam int REC_W   = rec_width(MVH_WIDTH, MVV_WIDTH, MBX_WIDTH, MBY_WIDTH);
  localparam int OFF_MBX = OFF_MBY + MBY_WIDTH;
  localparam int OFF_MVV = OFF_MBX + MBX_WIDTH;
  localparam int OFF_MVH = OFF_MVV + MVV_WIDTH;

  localparam logic [PTR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = 1;

  logic [PTR_WIDTH-1:0] wp;
  logic [PTR_WIDTH-1:0] rp;
  logic [PTR_WIDTH:0]   count;
  logic [REC_W-1:0]     wr_rec;
  logic [REC_W-1:0]     rd_rec;
  logic                 do_push;
  logic                 do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign level = count;

  // A push into a full queue is only accepted when a pop frees the head slot this cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign wr_rec = {in_mv_h, in_mv_v, in_mb_x, in_mb_y, in_mb_intra, in_block, in_coded, in_enable};

  m2vside_ram #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH),
    .WIDTH     (REC_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_push),
    .waddr (wp),
    .wdata (wr_rec),
    .raddr (rp),
    .rdata (rd_rec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PTR_ONE;
      if (do_pop)  rp <= rp + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Outputs behave like the old single latch: they move only on pop or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_mv_h     <= '0;
      out_mv_v     <= '0;
      out_mb_x     <= '0;
      out_mb_y     <= '0;
      out_mb_intra <= 1'b0;
      out_block    <= '0;
      out_coded    <= 1'b0;
      out_enable   <= 1'b0;
    end else if (do_pop) begin
      out_mv_h     <= rd_rec[OFF_MVH +: MVH_WIDTH];
      out_mv_v     <= rd_rec[OFF_MVV +: MVV_WIDTH];
      out_mb_x     <= rd_rec[OFF_MBX +: MBX_WIDTH];
      out_mb_y     <= rd_rec[OFF_MBY +: MBY_WIDTH];
      out_mb_intra <= rd_rec[OFF_INTRA];
      out_block    <= rd_rec[OFF_BLOCK +: 3];
      out_coded    <= rd_rec[OFF_CODED];
      out_enable   <= rd_rec[OFF_ENABLE];
    end else if (pop) begin
      out_enable   <= 1'b0;
    end
  end

`ifdef M2VSIDE_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push && full && !pop) ovf <= 1'b1;
      if (pop && empty)         udf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_m2vside_fifo.sv
// Self-checking bench for m2vside_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_m2vside_fifo;

  typedef struct packed {
    logic [15:0] mv_h;
    logic [14:0] mv_v;
    logic [5:0]  mb_x;
    logic [4:0]  mb_y;
    logic        mb_intra;
    logic [2:0]  block;
    logic        coded;
    logic        enable;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  rec_t        inRec = '0;
  logic [15:0] out_mv_h;
  logic [14:0] out_mv_v;
  logic [5:0]  out_mb_x;
  logic [4:0]  out_mb_y;
  logic        out_mb_intra;
  logic [2:0]  out_block;
  logic        out_coded;
  logic        out_enable;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic        ovf;
  logic        udf;

  int errorCount = 0;
  int checkCount = 0;

  rec_t modelQueue[$];
  rec_t modelOut;
  bit   modelOvf;
  bit   modelUdf;

  always #5 clk = ~clk;

  m2vside_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .in_mv_h      (inRec.mv_h),
    .in_mv_v      (inRec.mv_v),
    .in_mb_x      (inRec.mb_x),
    .in_mb_y      (inRec.mb_y),
    .in_mb_intra  (inRec.mb_intra),
    .in_block     (inRec.block),
    .in_coded     (inRec.coded),
    .in_enable    (inRec.enable),
    .push         (push),
    .pop          (pop),
    .out_mv_h     (out_mv_h),
    .out_mv_v     (out_mv_v),
    .out_mb_x     (out_mb_x),
    .out_mb_y     (out_mb_y),
    .out_mb_intra (out_mb_intra),
    .out_block    (out_block),
    .out_coded    (out_coded),
    .out_enable   (out_enable),
    .empty        (empty),
    .full         (full),
    .level        (level),
    .ovf          (ovf),
    .udf          (udf)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic rec_t randRec();
    rec_t r;
    r.mv_h     = 16'($urandom);
    r.mv_v     = 15'($urandom);
    r.mb_x     = 6'($urandom);
    r.mb_y     = 5'($urandom);
    r.mb_intra = 1'($urandom);
    r.block    = 3'($urandom_range(0, 5));
    r.coded    = 1'($urandom);
    r.enable   = 1'($urandom);
    return r;
  endfunction

  // Model advances one clock: reset wins, then pop of the old head, then push.
  task automatic modelStep(input bit rst, input bit psh, input bit pp, input rec_t r);
    int  sizeBefore;
    sizeBefore = modelQueue.size();
    if (rst) begin
      modelQueue.delete();
      modelOut = '0;
      modelOvf = 1'b0;
      modelUdf = 1'b0;
    end else begin
      if (pp) begin
        if (sizeBefore > 0) modelOut = modelQueue.pop_front();
        else begin
          modelOut.enable = 1'b0;
`ifdef M2VSIDE_FIFO_ERR_EN
          modelUdf = 1'b1;
`endif
        end
      end
      if (psh) begin
        if (sizeBefore < 4 || pp) modelQueue.push_back(r);
        else begin
`ifdef M2VSIDE_FIFO_ERR_EN
          modelOvf = 1'b1;
`endif
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit psh, input bit pp, input rec_t r);
    rec_t observedRec;
    @(negedge clk);
    reset = rst;
    push  = psh;
    pop   = pp;
    inRec = r;
    @(posedge clk);
    modelStep(rst, psh, pp, r);
    #1;
    observedRec = {out_mv_h, out_mv_v, out_mb_x, out_mb_y, out_mb_intra, out_block, out_coded, out_enable};
    checkOutput("out_rec", 64'(observedRec), 64'(modelOut));
    checkOutput("level",   64'(level), 64'(modelQueue.size()));
    checkOutput("empty",   64'(empty), 64'(modelQueue.size() == 0));
    checkOutput("full",    64'(full),  64'(modelQueue.size() == 4));
    checkOutput("ovf",     64'(ovf),   64'(modelOvf));
    checkOutput("udf",     64'(udf),   64'(modelUdf));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, randRec());
  endtask

  initial begin
    rec_t r;
    modelOut = '0;
    modelOvf = 1'b0;
    modelUdf = 1'b0;

    // reset and ordered push/pop of mb_x = 1, 2, 3
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 3; i++) begin
      r = randRec();
      r.mb_x = 6'(i);
      applyStimulus(1'b0, 1'b1, 1'b0, r);
    end
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      checkOutput("order_mb_x", 64'(out_mb_x), 64'(i));
      checkOutput("order_level", 64'(level), 64'(3 - i));
    end
    checkOutput("drained_empty", 64'(empty), 64'd1);

    // overflow: fifth push dropped
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, randRec());
    r = randRec();
    r.mv_h = 16'h7FFF;
    applyStimulus(1'b0, 1'b1, 1'b0, r);
    checkOutput("ovf_full", 64'(full), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0);
    idle();

    // underflow after holding mb_y = 5, enable = 1
    r = randRec();
    r.mb_y = 5'd5;
    r.enable = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, r);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("held_enable", 64'(out_enable), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkOutput("udf_enable", 64'(out_enable), 64'd0);
    checkOutput("udf_mb_y", 64'(out_mb_y), 64'd5);

    // full queue with simultaneous push and pop
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, randRec());
    applyStimulus(1'b0, 1'b1, 1'b1, randRec());
    checkOutput("pushpop_full_level", 64'(level), 64'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // simultaneous push and pop on an empty queue: no bypass
    applyStimulus(1'b0, 1'b1, 1'b1, randRec());
    checkOutput("pushpop_empty_level", 64'(level), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // ten records interleaved with pops so the pointers wrap
    applyStimulus(1'b0, 1'b1, 1'b0, randRec());
    applyStimulus(1'b0, 1'b1, 1'b0, randRec());
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, randRec());
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // reset with entries queued, then pop while empty
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, randRec());
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, randRec());
    checkOutput("reset_level", 64'(level), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), randRec());
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
